// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbitration path.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ... mod NUM_REQ.
module uart_rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // Scan from the farthest offset back towards ptr so the nearest requester wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    gnt = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional feature: define UART_ARB_LOCK_EN to add req_last and hold the grant until a last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  BUSY_TIMEOUT = 8,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             req_last,
`endif
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic [ID_W-1:0]                grant_id,
  output logic                           active,
  output logic                           err_pulse
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   active_q, active_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     pick_req, pick_gnt;
  logic [ID_W-1:0]        pick_idx, pick_next;
  logic                   pick_any;
  logic [UART_BYTE_W-1:0] pick_byte;
  logic                   can_accept, accept;

`ifdef UART_ARB_LOCK_EN
  logic                   lock_q, lock_d;
  logic                   pick_last;

  assign pick_last = req_last[pick_idx];
`endif

  // While locked only the requester that holds the lock (the last grantee) is eligible.
  always_comb begin
    pick_req = req_valid;
`ifdef UART_ARB_LOCK_EN
    if (lock_q) pick_req = req_valid & (NUM_REQ'(1) << grant_id_q);
`endif
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) pick_byte = req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  // A still-busy UART (e.g. after a mid-frame reset of this block) blocks new grants.
  assign can_accept = (state_q == ST_IDLE) && !tx_busy && !rst;
  assign req_ready  = can_accept ? pick_gnt : '0;
  assign accept     = can_accept && pick_any;
  assign pick_next  = ID_W'(rr_next(int'(pick_idx), NUM_REQ));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_data_d  = pick_byte;
          grant_id_d = pick_idx;
          tx_start_d = 1'b1;
          state_d    = ST_ISSUE;
`ifdef UART_ARB_LOCK_EN
          lock_d = !pick_last;
          if (pick_last) ptr_d = pick_next;
`else
          ptr_d = pick_next;
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged: drop the byte, keep ptr, release any lock.
          err_d   = 1'b1;
          state_d = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
      err_q      <= err_d;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;
  assign err_pulse = err_q;

endmodule
